// File: rtl/stepper_pkg.sv
// Shared definitions for the unipolar stepper phase driver: command codes,
// FSM state encoding and the half-step phase table.
package stepper_pkg;

   localparam logic [5:0] CMD_FWD  = 6'b000111;
   localparam logic [5:0] CMD_REV  = 6'b111000;
   localparam logic [5:0] CMD_STOP = 6'b000000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FWD    = 3'd1,
      ST_REV    = 3'd2,
      ST_SETTLE = 3'd3,
      ST_HOLD   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      DEC_STOP = 2'd0,
      DEC_FWD  = 2'd1,
      DEC_REV  = 2'd2
   } dec_e;

   // Entry 0 sits in the least significant nibble.
   localparam logic [31:0] PHASE_TABLE = {
      4'b1001, 4'b0001, 4'b0011, 4'b0010,
      4'b0110, 4'b0100, 4'b1100, 4'b1000
   };

   function automatic logic [3:0] phase_coil(input logic [2:0] idx);
      return PHASE_TABLE[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Free-running divider producing a one-clock tick every DIV_N clocks.
module step_tick_gen #(
   parameter int DIV_N = 24000,
   parameter int DIV_W = 15
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   assign tick_o = (cnt_q == DIV_W'(DIV_N - 1));

   always_comb begin
      cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/stepper_phase_driver.sv
// Stepper coil sequencer: decodes the direction command, steps the phase index
// on each divider tick, settles on reversals and releases coils after a hold.
module stepper_phase_driver
   import stepper_pkg::*;
#(
   parameter int DIV_N      = 24000,
   parameter int DIV_W      = 15,
   parameter int HALF_STEP  = 1,
   parameter int HOLD_TICKS = 250
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         cmd_i,
   output logic [3:0]         coil_o,
   output logic               step_pulse_o,
   output logic signed [15:0] pos_o,
   output logic               running_o,
   output logic               cmd_err_o
);

   localparam logic [2:0] INC    = (HALF_STEP != 0) ? 3'd1 : 3'd2;
   localparam int         HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

   logic [5:0]         cmd_q;
   logic [5:0]         cmd_prev_q;
   logic               err_q;
   state_e             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic signed [15:0] pos_q, pos_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               pulse_q, pulse_d;
   logic               tick;
   dec_e               dec;
   logic               cmd_illegal;

   step_tick_gen #(
      .DIV_N (DIV_N),
      .DIV_W (DIV_W)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (tick)
   );

   always_comb begin
      dec         = DEC_STOP;
      cmd_illegal = 1'b1;
      if (cmd_q == CMD_FWD) begin
         dec         = DEC_FWD;
         cmd_illegal = 1'b0;
      end else if (cmd_q == CMD_REV) begin
         dec         = DEC_REV;
         cmd_illegal = 1'b0;
      end else if (cmd_q == CMD_STOP) begin
         cmd_illegal = 1'b0;
      end
   end

   // Command changes take priority over a coincident tick, so a step is only
   // taken when the decoded command still matches the running direction.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pos_d   = pos_q;
      hold_d  = hold_q;
      pulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dec == DEC_FWD) begin
               state_d = ST_FWD;
            end else if (dec == DEC_REV) begin
               state_d = ST_REV;
            end
         end
         ST_FWD: begin
            if (dec == DEC_STOP) begin
               state_d = ST_HOLD;
               hold_d  = '0;
            end else if (dec == DEC_REV) begin
               state_d = ST_SETTLE;
            end else if (tick) begin
               idx_d   = idx_q + INC;
               pos_d   = pos_q + 16'sd1;
               pulse_d = 1'b1;
            end
         end
         ST_REV: begin
            if (dec == DEC_STOP) begin
               state_d = ST_HOLD;
               hold_d  = '0;
            end else if (dec == DEC_FWD) begin
               state_d = ST_SETTLE;
            end else if (tick) begin
               idx_d   = idx_q - INC;
               pos_d   = pos_q - 16'sd1;
               pulse_d = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (tick) begin
               if (dec == DEC_FWD) begin
                  state_d = ST_FWD;
               end else if (dec == DEC_REV) begin
                  state_d = ST_REV;
               end else begin
                  state_d = ST_HOLD;
                  hold_d  = '0;
               end
            end
         end
         ST_HOLD: begin
            if (dec == DEC_FWD) begin
               state_d = ST_FWD;
            end else if (dec == DEC_REV) begin
               state_d = ST_REV;
            end else if (tick) begin
               if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q      <= CMD_STOP;
         cmd_prev_q <= CMD_STOP;
         err_q      <= 1'b0;
         state_q    <= ST_IDLE;
         idx_q      <= 3'd0;
         pos_q      <= 16'sd0;
         hold_q     <= '0;
         pulse_q    <= 1'b0;
      end else begin
         cmd_q      <= cmd_i;
         cmd_prev_q <= cmd_q;
         err_q      <= cmd_illegal && (cmd_q != cmd_prev_q);
         state_q    <= state_d;
         idx_q      <= idx_d;
         pos_q      <= pos_d;
         hold_q     <= hold_d;
         pulse_q    <= pulse_d;
      end
   end

   // Decoding from registers keeps the coils dark the instant reset asserts.
   assign coil_o       = (state_q == ST_IDLE) ? 4'b0000 : phase_coil(idx_q);
   assign step_pulse_o = pulse_q;
   assign pos_o        = pos_q;
   assign running_o    = (state_q == ST_FWD) || (state_q == ST_REV);
   assign cmd_err_o    = err_q;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Randomised and directed bench for stepper_phase_driver; a half-step and a
// wave-drive instance run side by side against one behavioural model.
`timescale 1ns/1ps
module tb_stepper_phase_driver;

   localparam int DIV_N      = 4;
   localparam int DIV_W      = 3;
   localparam int HOLD_TICKS = 3;
   localparam logic [5:0] C_FWD  = 6'b000111;
   localparam logic [5:0] C_REV  = 6'b111000;
   localparam logic [5:0] C_STOP = 6'b000000;
   localparam logic [3:0] TBL [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                      4'b0010, 4'b0011, 4'b0001, 4'b1001};

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic [5:0] cmd = C_STOP;

   logic [3:0]         coil, coil_w;
   logic               step_pulse, step_pulse_w;
   logic signed [15:0] pos, pos_w;
   logic               running, running_w;
   logic               cmd_err, cmd_err_w;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stepper_phase_driver #(
      .DIV_N(DIV_N), .DIV_W(DIV_W), .HALF_STEP(1), .HOLD_TICKS(HOLD_TICKS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_i(cmd), .coil_o(coil),
      .step_pulse_o(step_pulse), .pos_o(pos), .running_o(running), .cmd_err_o(cmd_err)
   );

   stepper_phase_driver #(
      .DIV_N(DIV_N), .DIV_W(DIV_W), .HALF_STEP(0), .HOLD_TICKS(HOLD_TICKS)
   ) dut_w (
      .clk(clk), .rst_n(rst_n), .cmd_i(cmd), .coil_o(coil_w),
      .step_pulse_o(step_pulse_w), .pos_o(pos_w), .running_o(running_w), .cmd_err_o(cmd_err_w)
   );

   // Behavioural model: position/phase as integers, tick from elapsed clocks.
   typedef enum int {M_IDLE, M_FWD, M_REV, M_SETTLE, M_HOLD} mmode_t;
   mmode_t      m_mode;
   int          m_cyc, m_hold, m_ph, m_ph_w;
   logic [15:0] m_pos, m_pos_w;
   logic [15:0] m_pos_ofs = 16'd0;
   logic [5:0]  m_cq, m_cprev;
   logic        m_pulse, m_err;

   function automatic int dir_of(input logic [5:0] c);
      return (c == C_FWD) ? 1 : (c == C_REV) ? -1 : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= M_IDLE; m_cyc <= 0; m_hold <= 0; m_ph <= 0; m_ph_w <= 0;
         m_pos <= 16'd0; m_pos_w <= 16'd0; m_cq <= C_STOP; m_cprev <= C_STOP;
         m_pulse <= 1'b0; m_err <= 1'b0;
      end else begin
         automatic bit tk = ((m_cyc % DIV_N) == DIV_N - 1);
         automatic int d  = dir_of(m_cq);
         automatic int want = (m_mode == M_FWD) ? 1 : -1;
         m_cq    <= cmd;
         m_cprev <= m_cq;
         m_err   <= (m_cq != m_cprev) && (d == 0) && (m_cq != C_STOP);
         m_cyc   <= m_cyc + 1;
         m_pulse <= 1'b0;
         case (m_mode)
            M_IDLE: if (d == 1) m_mode <= M_FWD; else if (d == -1) m_mode <= M_REV;
            M_FWD, M_REV: begin
               if (d == 0) begin
                  m_mode <= M_HOLD; m_hold <= 0;
               end else if (d != want) begin
                  m_mode <= M_SETTLE;
               end else if (tk) begin
                  m_ph    <= (m_ph + want + 8) % 8;
                  m_ph_w  <= (m_ph_w + 2 * want + 8) % 8;
                  m_pos   <= m_pos + 16'(want);
                  m_pos_w <= m_pos_w + 16'(want);
                  m_pulse <= 1'b1;
               end
            end
            M_SETTLE: if (tk) begin
               if (d == 1) m_mode <= M_FWD;
               else if (d == -1) m_mode <= M_REV;
               else begin m_mode <= M_HOLD; m_hold <= 0; end
            end
            M_HOLD: begin
               if (d == 1) m_mode <= M_FWD;
               else if (d == -1) m_mode <= M_REV;
               else if (tk) begin
                  if (m_hold + 1 == HOLD_TICKS) m_mode <= M_IDLE;
                  else m_hold <= m_hold + 1;
               end
            end
            default: m_mode <= M_IDLE;
         endcase
      end
   end

   logic [45:0] act, exp_v;
   always_comb begin
      automatic logic run = (m_mode == M_FWD) || (m_mode == M_REV);
      automatic logic [3:0] ec  = (m_mode == M_IDLE) ? 4'b0000 : TBL[m_ph];
      automatic logic [3:0] ecw = (m_mode == M_IDLE) ? 4'b0000 : TBL[m_ph_w];
      act   = {coil, pos, step_pulse, running, cmd_err,
               coil_w, pos_w, step_pulse_w, running_w, cmd_err_w};
      exp_v = {ec, m_pos + m_pos_ofs, m_pulse, run, m_err,
               ecw, m_pos_w, m_pulse, run, m_err};
   end

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({coil, pos, step_pulse, running, cmd_err, coil_w, pos_w} !== '0) begin
         failures++;
         $display("FAIL reset_values actual=%h required=0", {coil, pos, step_pulse, running, cmd_err, coil_w, pos_w});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_forward();
      int last_p = -1;
      cmd = C_FWD;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_v) begin
            failures++;
            $display("FAIL fwd_cycle t=%0t actual=%h required=%h", $time, act, exp_v);
         end
         if (step_pulse) begin
            if (last_p >= 0) begin
               checks++;
               if (c - last_p != DIV_N) begin
                  failures++;
                  $display("FAIL fwd_period actual=%0d required=%0d", c - last_p, DIV_N);
               end
            end
            last_p = c;
         end
      end
   endtask

   task automatic test_reversal();
      int last_f = -1;
      int first_r = -1;
      cmd = C_FWD;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (step_pulse_w) last_f = c;
      end
      cmd = C_REV;
      for (int c = 20; c < 60; c++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_v) begin
            failures++;
            $display("FAIL rev_cycle t=%0t actual=%h required=%h", $time, act, exp_v);
         end
         if (step_pulse_w && first_r < 0) first_r = c;
      end
      checks++;
      if (first_r < 0 || last_f < 0 || (first_r - last_f) < 2 * DIV_N) begin
         failures++;
         $display("FAIL settle_gap actual=%0d required>=%0d", first_r - last_f, 2 * DIV_N);
      end
   endtask

   task automatic test_stop_hold();
      cmd = C_FWD;
      repeat (20) @(negedge clk);
      cmd = C_STOP;
      @(negedge clk);
      checks++;
      if (running !== 1'b1) begin
         failures++;
         $display("FAIL stop_running_n1 actual=%b required=1", running);
      end
      @(negedge clk);
      checks++;
      if (running !== 1'b0) begin
         failures++;
         $display("FAIL stop_running_n2 actual=%b required=0", running);
      end
      for (int c = 0; c < HOLD_TICKS * DIV_N + 4; c++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_v) begin
            failures++;
            $display("FAIL hold_cycle t=%0t actual=%h required=%h", $time, act, exp_v);
         end
      end
      checks++;
      if (coil !== 4'b0000 || coil_w !== 4'b0000) begin
         failures++;
         $display("FAIL hold_release actual=%b/%b required=0000", coil, coil_w);
      end
   endtask

   task automatic test_illegal();
      int errs = 0;
      logic signed [15:0] held;
      cmd = C_FWD;
      repeat (10) @(negedge clk);
      cmd = 6'b010101;
      repeat (2) @(negedge clk);
      held = pos;
      errs = cmd_err ? 1 : 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (cmd_err) errs++;
         checks++;
         if (act !== exp_v) begin
            failures++;
            $display("FAIL illegal_cycle t=%0t actual=%h required=%h", $time, act, exp_v);
         end
      end
      checks++;
      if (errs != 1) begin
         failures++;
         $display("FAIL cmd_err_count actual=%0d required=1", errs);
      end
      checks++;
      if (pos !== held || running !== 1'b0) begin
         failures++;
         $display("FAIL illegal_stop actual=%0d/%b required=%0d/0", pos, running, held);
      end
   endtask

   task automatic test_wrap();
      bit saw_min = 0;
      cmd = C_STOP;
      @(negedge clk);
      m_pos_ofs = 16'h7FFD - m_pos;
      force dut.pos_q = 16'sh7FFD;
      @(negedge clk);
      release dut.pos_q;
      cmd = C_FWD;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (pos == -16'sd32768) saw_min = 1;
         checks++;
         if (act !== exp_v) begin
            failures++;
            $display("FAIL wrap_cycle t=%0t actual=%h required=%h", $time, act, exp_v);
         end
      end
      checks++;
      if (!saw_min) begin
         failures++;
         $display("FAIL wrap_seen actual=%0d required=pass -32768", pos);
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 40; s++) begin
         automatic int sel = $urandom_range(0, 4);
         automatic int len = $urandom_range(1, 15);
         cmd = (sel == 0) ? C_FWD : (sel == 1) ? C_REV : (sel == 2) ? C_STOP :
               (sel == 3) ? C_FWD : 6'($urandom);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            checks++;
            if (act !== exp_v) begin
               failures++;
               $display("FAIL random_cycle t=%0t cmd=%b actual=%h required=%h", $time, cmd, act, exp_v);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit got = 0;
      cmd = C_REV;
      repeat (12) @(negedge clk);
      #2 rst_n = 1'b0;
      m_pos_ofs = 16'd0;
      #1;
      checks++;
      if (coil !== 4'b0000 || pos !== 16'sd0 || coil_w !== 4'b0000) begin
         failures++;
         $display("FAIL async_reset actual=%b/%0d required=0000/0", coil, pos);
      end
      cmd = C_FWD;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_v) begin
            failures++;
            $display("FAIL post_reset_cycle t=%0t actual=%h required=%h", $time, act, exp_v);
         end
         if (step_pulse) begin
            got = 1;
            checks++;
            if (coil !== 4'b1100 || pos !== 16'sd1) begin
               failures++;
               $display("FAIL first_step actual=%b/%0d required=1100/1", coil, pos);
            end
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL first_step_timeout actual=none required=step_pulse");
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reversal();
      test_stop_hold();
      test_illegal();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
